// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM state encoding, bit-period math, line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; the reset value is chosen per use
// so an idle line does not look active while reset is released.
module sync_2ff #(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_char_rx.sv
// UART receiver (start + PAYLOAD_BITS + stop, LSB first) with mid-bit sampling and held CHAR_O.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_char_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    CLK_I,
    input  logic                    RST_N_I,
    input  logic                    RX_I,
    output logic [PAYLOAD_BITS-1:0] CHAR_O,
    output logic                    VALID_O,
    output logic                    FRAME_ERR_O,
    output logic                    PARITY_ERR_O
);

    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CPB - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(PAYLOAD_BITS - 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_char_rx: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    logic rx_s;

    sync_2ff #(.WIDTH(1), .RST_VAL(UART_IDLE_LEVEL)) u_rx_sync (
        .clk   (CLK_I),
        .rst_n (RST_N_I),
        .d     (RX_I),
        .q     (rx_s)
    );

    uart_rx_state_t          state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [BW-1:0]           bit_idx, bit_nxt;
    logic [PAYLOAD_BITS-1:0] shreg, sh_nxt, char_nxt;
    logic                    valid_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                    pmis, pmis_nxt, perr_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        char_nxt  = CHAR_O;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pmis_nxt  = pmis;
        perr_nxt  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = ST_START;
            end
            // Half-bit wait re-checks the start bit so short glitches are dropped.
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
                    pmis_nxt  = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rx_s, shreg[PAYLOAD_BITS-1:1]};
                    bit_nxt = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt   = '0;
                    pmis_nxt  = (rx_s != ^shreg);
                    state_nxt = ST_STOP;
                end
            end
`endif
            // A low stop bit outranks a parity mismatch; only the framing error is reported.
            ST_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (pmis) begin
                        perr_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
`endif
                    end else begin
                        char_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            CHAR_O      <= '0;
            VALID_O     <= 1'b0;
            FRAME_ERR_O <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_nxt;
            shreg       <= sh_nxt;
            CHAR_O      <= char_nxt;
            VALID_O     <= valid_nxt;
            FRAME_ERR_O <= ferr_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            pmis         <= 1'b0;
            PARITY_ERR_O <= 1'b0;
        end else begin
            pmis         <= pmis_nxt;
            PARITY_ERR_O <= perr_nxt;
        end
    end
`else
    assign PARITY_ERR_O = 1'b0;
`endif

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed + random frame bench for uart_char_rx at 16 clocks per bit; an event-count
// reference model predicts CHAR_O and pulse counts from frame contents.
module tb_uart_char_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int P      = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = P + 2;
`else
    localparam int NBITS  = P + 1;
`endif
    // Negedges from the RX_I fall to VALID_O seen high: 2 sync flops, 1 IDLE detect,
    // then the stop-bit sample position, with VALID_O visible right after that edge.
    localparam int LAT    = 3 + NBITS * CPB + CPB / 2;

    logic         clk;
    logic         rst_n;
    logic         rx;
    logic [P-1:0] char_o;
    logic         valid_o, ferr_o, perr_o;

    uart_char_rx #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .BAUD         (BAUD),
        .PAYLOAD_BITS (P)
    ) dut (
        .CLK_I        (clk),
        .RST_N_I      (rst_n),
        .RX_I         (rx),
        .CHAR_O       (char_o),
        .VALID_O      (valid_o),
        .FRAME_ERR_O  (ferr_o),
        .PARITY_ERR_O (perr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events
    int           n_valid = 0, n_ferr = 0, n_perr = 0;
    int           last_valid_cyc = 0;
    logic [P-1:0] got_q[$];
    logic [P-1:0] prev_char = '0;
    logic         excl_bad = 1'b0, char_bad = 1'b0;

    always @(negedge clk) begin
        if (valid_o) begin
            n_valid++;
            last_valid_cyc = cyc;
            got_q.push_back(char_o);
        end
        if (ferr_o) n_ferr++;
        if (perr_o) n_perr++;
        if ((int'(valid_o) + int'(ferr_o) + int'(perr_o)) > 1) excl_bad = 1'b1;
        if (rst_n && !valid_o && char_o !== prev_char) char_bad = 1'b1;
        prev_char = char_o;
    end

    // Reference model state
    int           exp_valid = 0, exp_ferr = 0, exp_perr = 0;
    logic [P-1:0] exp_char = '0;
    int           fall_cyc = 0;
    int           n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_frame(input logic [P-1:0] d, input logic stop, input logic par);
        if (!stop) exp_ferr++;
`ifdef UART_RX_PARITY_EN
        else if (par != ^d) exp_perr++;
`endif
        else begin
            exp_valid++;
            exp_char = d;
        end
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Leaves RX_I at the stop-bit level; caller decides what follows.
    task automatic send_frame(input logic [P-1:0] d, input logic stop, input logic par);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < P; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
        model_frame(d, stop, par);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid_cnt"}, n_valid, exp_valid);
        check({tag, "_ferr_cnt"}, n_ferr, exp_ferr);
        check({tag, "_perr_cnt"}, n_perr, exp_perr);
        check({tag, "_char"}, char_o, exp_char);
    endtask

    initial begin
        logic [P-1:0] d;
        logic         stop, par;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_char", char_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_ferr", ferr_o, 0);
        check("rst_perr", perr_o, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame and its exact latency
        d = 8'h41;
        send_frame(d, 1'b1, ^d);
        repeat (CPB) @(negedge clk);
        check_state("f41");
        check("f41_latency", last_valid_cyc - fall_cyc, LAT);

        // Start-bit glitch
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_state("glitch");
        d = 8'h42;
        send_frame(d, 1'b1, ^d);
        repeat (CPB) @(negedge clk);
        check_state("f42");

        // Framing error with a held break
        d = 8'h55;
        send_frame(d, 1'b0, ^d);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_state("ferr55");
        d = 8'h43;
        send_frame(d, 1'b1, ^d);
        repeat (CPB) @(negedge clk);
        check_state("f43");

        // Back-to-back, no idle bits
        d = 8'h48;
        send_frame(d, 1'b1, ^d);
        d = 8'h49;
        send_frame(d, 1'b1, ^d);
        repeat (CPB) @(negedge clk);
        check_state("b2b");
        check("b2b_first", got_q[got_q.size()-2], 8'h48);
        check("b2b_second", got_q[got_q.size()-1], 8'h49);

        // Reset mid data bit 3 of 0x7E
        d = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx = d[3];
        repeat (CPB / 2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_char = '0;
        check("midrst_char", char_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_ferr", ferr_o, 0);
        check("midrst_perr", perr_o, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_state("postrst_idle");
        d = 8'h5A;
        send_frame(d, 1'b1, ^d);
        repeat (CPB) @(negedge clk);
        check_state("f5a");

        // Zero is a valid character
        d = 8'h00;
        send_frame(d, 1'b1, ^d);
        repeat (CPB) @(negedge clk);
        check_state("f00");

`ifdef UART_RX_PARITY_EN
        d = 8'h03;
        send_frame(d, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        check_state("par_bad");
        send_frame(d, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        check_state("par_good");
`endif

        // Random frames, random gaps, occasional bad stop / parity
        for (int k = 0; k < 12; k++) begin
            d    = P'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = ($urandom_range(0, 3) != 0) ? ^d : ~^d;
            send_frame(d, stop, par);
            if (!stop) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                rx = 1'b1;
                repeat (CPB) @(negedge clk);
            end
            repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
            check("rnd_valid_cnt", n_valid, exp_valid);
            check("rnd_ferr_cnt", n_ferr, exp_ferr);
            check("rnd_perr_cnt", n_perr, exp_perr);
            check("rnd_char", char_o, exp_char);
        end
        repeat (2 * CPB) @(negedge clk);

        check("pulse_exclusive", excl_bad, 0);
        check("char_held", char_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
